instr_encoder: RTL and testbench

- Inverse of the core's immediate/field decode. Accepts decoded instruction fields plus a full 32-bit immediate and packs them into a 32-bit RV32I instruction word.
- Range-checks the immediate for the selected format.
- Buffers results in a 2-entry FIFO and presents them, with a byte address, to an instruction-memory loader or a testbench program builder.
- Sits between the program-load path and the instruction ROM/RAM write port.

---
 rtl/instr_encoder.sv | 143 ++++++++++++++
 tb/tb_instr_encoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction packer with immediate range check and 2-entry output FIFO
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] word_count,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  localparam logic [1:0] DEPTH_L = 2'(FIFO_DEPTH);

  fmt_e               fmt;
  logic               bad_op;
  logic               range_err;
  logic signed [31:0] imm_s;
  logic [31:0]        instr_d;
  logic               err_d;

  logic [32:0] mem_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic [32:0] head;
  logic        push, pop;

  always_comb begin
    fmt    = FMT_I;
    bad_op = 1'b0;
    case (in_opcode)
      7'b0110011:                         fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b1100011:                         fmt = FMT_B;
      7'b0110111, 7'b0010111:             fmt = FMT_U;
      7'b1101111:                         fmt = FMT_J;
      default:                            bad_op = 1'b1;
    endcase
  end

  // Word is always packed from truncated immediate bits, even when flagged.
  always_comb begin
    imm_s     = in_imm;
    instr_d   = '0;
    range_err = 1'b0;
    case (fmt)
      FMT_R: begin
        instr_d = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        instr_d   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_B: begin
        instr_d   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        range_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
      end
      FMT_U: begin
        instr_d   = {in_imm[31:12], in_rd, in_opcode};
        range_err = (in_imm[11:0] != 12'h000);
      end
      FMT_J: begin
        instr_d   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        range_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
      end
      default: begin
        instr_d   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
    endcase
    err_d = range_err || bad_op;
  end

  assign head       = mem_q[rd_ptr_q];
  assign in_ready   = (count_q != DEPTH_L);
  assign out_valid  = (count_q != 2'd0);
  assign out_instr  = out_valid ? head[31:0] : 32'h0;
  assign out_err    = out_valid & head[32];
  assign out_addr   = addr_q;
  assign word_count = wcnt_q;
  assign err_count  = ecnt_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    ecnt_d  = ecnt_q;
    if (push && !pop) count_d = count_q + 2'd1;
    if (pop && !push) count_d = count_q - 2'd1;
    if (pop) begin
      addr_d = addr_q + 32'd4;
      if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
      if (out_err && (ecnt_q != 8'hFF)) ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      addr_q   <= BASE_ADDR;
      wcnt_q   <= 16'd0;
      ecnt_q   <= 8'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {err_d, instr_d};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with randomized stimulus
module tb_instr_encoder;

  localparam logic [31:0] TB_BASE = 32'h0000_1000;

  logic        clk, reset, clear;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        out_err;
  logic [15:0] word_count;
  logic [7:0]  err_count;

  instr_encoder #(.BASE_ADDR(TB_BASE), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .word_count(word_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] q[$];
  logic [32:0] pend;
  int unsigned mw, me;
  logic [31:0] pops;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: RV32I packing from field arithmetic, range by signed integer compare.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
    longint      v;
    logic [31:0] w;
    logic [31:0] base;
    logic        e;
    v    = longint'($signed(imm));
    base = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
    e    = 1'b0;
    case (op)
      7'h33: w = base | (32'(rs2) << 20) | (32'(f7) << 25);
      7'h13, 7'h03, 7'h67: begin
        w = base | ((imm & 32'hFFF) << 20);
        e = (v < -2048) || (v > 2047);
      end
      7'h23: begin
        w = 32'(op) | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
            | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
        e = (v < -2048) || (v > 2047);
      end
      7'h63: begin
        w = 32'(op) | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
            | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
            | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
        e = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      7'h37, 7'h17: begin
        w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
        e = (imm % 4096) != 0;
      end
      7'h6F: begin
        w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
            | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 20) & 32'h1) << 31);
        e = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: begin
        w = base | ((imm & 32'hFFF) << 20);
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  // Monitor: transfers are decided from the model's own occupancy view.
  always @(negedge clk) begin
    int sz;
    if (reset || clear) begin
      q.delete();
      mw = 0; me = 0; pops = 32'h0;
    end else begin
      sz = q.size();
      check("in_ready", 32'(in_ready), 32'(sz < 2));
      check("out_valid", 32'(out_valid), 32'(sz != 0));
      check("word_count", 32'(word_count), mw);
      check("err_count", 32'(err_count), me);
      if (sz != 0) begin
        check("out_instr", out_instr, q[0][31:0]);
        check("out_err", 32'(out_err), 32'(q[0][32]));
        check("out_addr", out_addr, TB_BASE + pops * 4);
        if (out_ready) begin
          if (q[0][32] && me < 255) me++;
          if (mw < 65535) mw++;
          pops = pops + 1;
          void'(q.pop_front());
        end
      end
      if (in_valid && sz < 2) q.push_back(pend);
    end
  end

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [32:0] exp);
    int t;
    pend = exp;
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 60);
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready stuck at %b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
    send(op, rd, rs1, rs2, f3, f7, imm, model(op, rd, rs1, rs2, f3, f7, imm));
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d words left required 0", q.size());
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    check({tag, "_out_addr"}, out_addr, TB_BASE);
    check({tag, "_out_instr"}, out_instr, 32'h0);
    check({tag, "_out_err"}, 32'(out_err), 32'h0);
    check({tag, "_word_count"}, 32'(word_count), 32'h0);
    check({tag, "_err_count"}, 32'(err_count), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  bit         rnd_done;

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; pend = '0;
    repeat (3) @(posedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    out_ready = 1'b1;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, {1'b0, 32'h0050_0093});
    drain();

    pulse_clear();
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, {1'b0, 32'h0020_A423});
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, {1'b0, 32'hFE00_0EE3});
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, {1'b0, 32'h0080_00EF});
    drain();
    @(negedge clk);
    check("stream_word_count", 32'(word_count), 32'd3);
    check("stream_out_addr", out_addr, TB_BASE + 32'd12);
    @(posedge clk); #1;

    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, {1'b0, 32'h1234_52B7});
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, {1'b1, 32'h1234_52B7});
    drain();
    @(negedge clk);
    check("lui_err_count", 32'(err_count), 32'd1);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send_m(7'h33, 5'd3, 5'd4, 5'd5, 3'd7, 7'h20, 32'h0);
    send_m(7'h13, 5'd6, 5'd7, 5'd0, 3'd1, 7'd0, 32'hFFFF_F800);
    @(negedge clk);
    check("bp_in_ready_full", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    fork
      send_m(7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    join
    drain();

    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, {1'b1, 32'h8000_0093});
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, {1'b0, 32'h0000_0363});
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, {1'b1, 32'h0000_0263});
    send(7'h7F, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd3, {1'b1, 32'h0031_00FF});
    send_m(7'h6F, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
    send_m(7'h6F, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
    send_m(7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'hFFFF_F7FF);
    drain();

    pulse_clear();
    for (int i = 0; i < 5; i++)
      send_m(7'h13, 5'(i), 5'(i + 1), 5'd0, 3'd0, 7'd0, 32'(i * 3));
    drain();
    out_ready = 1'b0;
    send_m(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0);
    send_m(7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'h0);
    @(negedge clk);
    check("pre_clear_word_count", 32'(word_count), 32'd5);
    check("pre_clear_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check_idle("clear");
    @(posedge clk); #1;

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] imm;
          logic [6:0]  op;
          op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
          case ($urandom_range(0, 4))
            0: imm = 32'(int'($urandom_range(0, 40)) - 20);
            1: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            2: imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
            3: imm = $urandom;
            default: imm = $urandom & 32'hFFFF_F000;
          endcase
          send_m(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    out_ready = 1'b0;
    send_m(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("final_reset");
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
